mult_table_seq: RTL and testbench

MULT_TABLE_SEQ -- requirements
Module: mult_table_seq

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_pipe.sv | 64 ++++++
 rtl/mult_table_seq.sv | 140 ++++++++++++++
 tb/tb_mult_table_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplication-table sequencer: FSM encoding and
// legal parameter limits.
package mult_pkg;

    localparam int unsigned WMin   = 2;
    localparam int unsigned WMax   = 16;
    localparam int unsigned LatMin = 1;
    localparam int unsigned LatMax = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_pipe.sv
// LAT-stage unsigned multiplier; operands and the last flag ride alongside the
// product so every output stays aligned. Stages advance only when en=1.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_last,
    output logic           out_valid,
    output logic [W-1:0]   out_a,
    output logic [W-1:0]   out_b,
    output logic [2*W-1:0] out_p,
    output logic           out_last
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] last_q;
    logic [W-1:0]   a_q [LAT];
    logic [W-1:0]   b_q [LAT];
    logic [2*W-1:0] p_q [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (en) begin
            vld_q[0]  <= in_valid;
            last_q[0] <= in_valid & in_last;
            a_q[0]    <= in_a;
            b_q[0]    <= in_b;
            p_q[0]    <= (2*W)'(in_a) * (2*W)'(in_b);
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                a_q[i]    <= a_q[i-1];
                b_q[i]    <= b_q[i-1];
                p_q[i]    <= p_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_last  = last_q[LAT-1];
    assign out_a     = a_q[LAT-1];
    assign out_b     = b_q[LAT-1];
    assign out_p     = p_q[LAT-1];

endmodule

// File: rtl/mult_table_seq.sv
// Walks a 2-D operand range (a inner, b outer) through a pipelined multiplier
// with ready/valid backpressure, counting accepted products.
module mult_table_seq
    import mult_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   a_lo,
    input  logic [W-1:0]   a_hi,
    input  logic [W-1:0]   b_lo,
    input  logic [W-1:0]   b_hi,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_a,
    output logic [W-1:0]   out_b,
    output logic [2*W-1:0] out_p,
    output logic           out_last,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W:0]   count
);

    if (W < WMin || W > WMax || LAT < LatMin || LAT > LatMax) begin : g_param_err
        $error("mult_table_seq: W or LAT outside legal range");
    end

    state_e       state_q;
    logic [W-1:0] a_lo_q, a_hi_q, b_lo_q, b_hi_q;
    logic [W-1:0] a_cnt_q, b_cnt_q;
    logic         busy_q, done_q, err_q;
    logic [2*W:0] count_q;

    logic en, issue_last, accept, flush;

    assign en         = !(out_valid && !out_ready);
    assign issue_last = (a_cnt_q == a_hi_q) && (b_cnt_q == b_hi_q);
    assign accept     = out_valid && out_ready;
    assign flush      = abort && (state_q != StIdle);

    mult_pipe #(
        .W   (W),
        .LAT (LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (state_q == StRun),
        .in_a      (a_cnt_q),
        .in_b      (b_cnt_q),
        .in_last   (issue_last),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_p     (out_p),
        .out_last  (out_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_lo_q  <= '0;
            a_hi_q  <= '0;
            b_lo_q  <= '0;
            b_hi_q  <= '0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Abort wins over acceptance, so an aborted product is never counted.
            if (accept && !flush) begin
                count_q <= count_q + (2*W+1)'(1);
            end
            if (flush) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (a_lo <= a_hi && b_lo <= b_hi) begin
                                a_lo_q  <= a_lo;
                                a_hi_q  <= a_hi;
                                b_lo_q  <= b_lo;
                                b_hi_q  <= b_hi;
                                a_cnt_q <= a_lo;
                                b_cnt_q <= b_lo;
                                count_q <= '0;
                                busy_q  <= 1'b1;
                                state_q <= StRun;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (en) begin
                            if (issue_last) begin
                                state_q <= StDrain;
                            end else if (a_cnt_q == a_hi_q) begin
                                a_cnt_q <= a_lo_q;
                                b_cnt_q <= b_cnt_q + W'(1);
                            end else begin
                                a_cnt_q <= a_cnt_q + W'(1);
                            end
                        end
                    end
                    StDrain: begin
                        if (accept && out_last) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: tb/tb_mult_table_seq.sv
// Directed bench for mult_table_seq: expected products are queued when a run is
// started and compared in order as the DUT hands them off.
module tb_mult_table_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  a_lo, a_hi, b_lo, b_hi;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_a, out_b;
    logic [15:0] out_p;
    logic        out_last;
    logic        busy, done, err;
    logic [16:0] count;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   acc      = 0;
    int   ready_mode = 0;
    int   ready_idx  = 0;
    bit   ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic        prev_stall = 1'b0;
    logic [32:0] prev_bus   = '0;
    logic [15:0] last_p     = '0;
    logic        last_last  = 1'b0;

    mult_table_seq #(
        .W   (8),
        .LAT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .a_lo      (a_lo),
        .a_hi      (a_hi),
        .b_lo      (b_lo),
        .b_hi      (b_hi),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_p     (out_p),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ready pattern: constant 1, or the repeating 1,0,0,1 stall pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = ready_pat[ready_idx];
                ready_idx = (ready_idx + 1) % 4;
            end
        end
    end

    // Scoreboard consumer and stall-stability monitor.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_a, out_b, out_p, out_last}, prev_bus);
            end
            if (out_valid && out_ready && !abort) begin
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("prod_a", out_a, e.a);
                    check("prod_b", out_b, e.b);
                    check("prod_p", out_p, e.p);
                    check("prod_last", out_last, e.last);
                end
                last_p    = out_p;
                last_last = out_last;
                acc++;
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_bus   = {out_a, out_b, out_p, out_last};
        end
    end

    task automatic start_run(input int alo, input int ahi, input int blo, input int bhi);
        for (int b = blo; b <= bhi; b++) begin
            for (int a = alo; a <= ahi; a++) begin
                exp_t e;
                e.a    = 8'(a);
                e.b    = 8'(b);
                e.p    = 16'(a * b);
                e.last = (a == ahi) && (b == bhi);
                sb.push_back(e);
            end
        end
        acc = 0;
        @(posedge clk);
        #1;
        a_lo  = 8'(alo);
        a_hi  = 8'(ahi);
        b_lo  = 8'(blo);
        b_hi  = 8'(bhi);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit bad;
        int lat;

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        a_lo = '0; a_hi = '0; b_lo = '0; b_hi = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Full 8x8 table, ready held high.
        start_run(1, 8, 2, 9);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("r1_latency", lat, 4);
        check("r1_first_a", out_a, 1);
        check("r1_first_b", out_b, 2);
        check("r1_first_p", out_p, 2);
        check("r1_busy", busy, 1);
        // A start during the run must be ignored.
        @(posedge clk);
        #1;
        a_lo = 8'd0; a_hi = 8'd0; b_lo = 8'd0; b_hi = 8'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(300, seen);
        check("r1_done_seen", seen, 1);
        check("r1_busy_at_done", busy, 0);
        check("r1_count", count, 64);
        check("r1_sb_empty", sb.size(), 0);
        @(negedge clk);
        check("r1_done_one_cycle", done, 0);

        // Same table under the 1,0,0,1 ready pattern.
        ready_idx  = 0;
        ready_mode = 1;
        start_run(1, 8, 2, 9);
        wait_done(1000, seen);
        check("r2_done_seen", seen, 1);
        check("r2_count", count, 64);
        check("r2_sb_empty", sb.size(), 0);
        ready_mode = 0;

        // Single-point maximum operands.
        start_run(255, 255, 255, 255);
        wait_done(50, seen);
        check("r3_done_seen", seen, 1);
        check("r3_count", count, 1);
        check("r3_p", last_p, 65025);
        check("r3_last", last_last, 1);
        check("r3_sb_empty", sb.size(), 0);

        // Invalid range.
        @(posedge clk);
        #1;
        a_lo = 8'd5; a_hi = 8'd3; b_lo = 8'd0; b_hi = 8'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("r4_err_pulse", err, 1);
        check("r4_busy", busy, 0);
        @(negedge clk);
        check("r4_err_clear", err, 0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad = 1'b1;
        end
        check("r4_quiet", bad, 0);

        // Abort after the 10th accepted product.
        start_run(1, 8, 2, 9);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (acc == 10) begin
                seen = 1'b1;
                break;
            end
        end
        check("r5_reached_10", seen, 1);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("r5_valid_cleared", out_valid, 0);
        check("r5_busy", busy, 0);
        check("r5_no_done", done, 0);
        check("r5_count", count, 10);
        sb.delete();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || out_valid) bad = 1'b1;
        end
        check("r5_quiet", bad, 0);
        start_run(1, 3, 1, 1);
        wait_done(50, seen);
        check("r5_rerun_done", seen, 1);
        check("r5_rerun_count", count, 3);
        check("r5_rerun_sb_empty", sb.size(), 0);

        // Reset asserted while draining.
        start_run(1, 4, 1, 4);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (acc == 14) begin
                seen = 1'b1;
                break;
            end
        end
        check("r6_reached_drain", seen, 1);
        #1 rst = 1'b0;
        #1;
        check("r6_rst_valid", out_valid, 0);
        check("r6_rst_last", out_last, 0);
        check("r6_rst_done", done, 0);
        check("r6_rst_err", err, 0);
        check("r6_rst_busy", busy, 0);
        check("r6_rst_count", count, 0);
        check("r6_rst_a", out_a, 0);
        check("r6_rst_b", out_b, 0);
        check("r6_rst_p", out_p, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        start_run(1, 2, 1, 2);
        wait_done(50, seen);
        check("r6_rerun_done", seen, 1);
        check("r6_rerun_count", count, 4);
        check("r6_rerun_sb_empty", sb.size(), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
